ppu_ap_master: RTL
==================

Name: ppu_ap_master

Overview:
- Initiator side of the ap_ctrl_hs-style PPU handshake (ap_start / ap_done / ap_ready / ap_continue).
- Accepts operand/opcode commands from an upstream valid/ready stream and buffers them in a small FIFO.
- Issues one operation at a time to a PPU ap wrapper, captures the result, and returns it on a downstream valid/ready stream.
- Sits between a host/DMA command source and the PPU core wrapper.

Parameters:
- WORD, 32, operand/result width; must match the PPU wrapper.
- OP_SIZE, 3, opcode width.
- DEPTH, 4, command FIFO entries; power of two, at least 2.
- TIMEOUT, 255, max cycles to wait for ap_done; used only with the optional feature.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst_n  in  1  reset; synchronous, active-low.
- cmd_valid  in  1  upstream command valid.
- cmd_ready  out  1  FIFO not full.
- cmd_in1  in  WORD  operand 1.
- cmd_in2  in  WORD  operand 2.
- cmd_op  in  OP_SIZE  opcode.
- ap_start  out  1  start request to the PPU.
- ap_continue  out  1  result-consumed acknowledge to the PPU.
- ppu_in1  out  WORD  operand 1 to the PPU.
- ppu_in2  out  WORD  operand 2 to the PPU.
- ppu_op  out  OP_SIZE  opcode to the PPU.
- ap_done  in  1  PPU result valid.
- ap_ready  in  1  PPU accepted inputs; equal to ap_done on the current PPU.
- ppu_out  in  WORD  PPU result.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.
- res_data  out  WORD  captured result.
- busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- issued_cnt  out  16  operations completed; wraps modulo 2^16.

Behaviour:
- Reset (ap_rst_n=0 at a clock edge) forces:
  - all outputs to 0, except cmd_ready=1;
  - FIFO empty, FSM in IDLE, issued_cnt=0.
  - Reset mid-operation abandons the in-flight op and drops ap_start on the next edge.
- FIFO:
  - Push when cmd_valid & cmd_ready.
  - cmd_ready = !full.
  - Simultaneous push and pop when full is not allowed; cmd_ready is already 0 in that case.
  - Simultaneous push and pop when empty is impossible, because the head must already be present to issue.
  - Pointers wrap modulo DEPTH; an occupancy counter of width log2(DEPTH)+1 distinguishes full from empty.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If the FIFO is non-empty, register the head into ppu_in1/ppu_in2/ppu_op and set ap_start=1.
  - Go to ISSUE on that edge, so the first ap_start is one cycle after the head becomes visible.
- ISSUE:
  - Hold ap_start=1 and the operands stable while ap_done=0.
  - On a cycle with ap_done=1:
    - capture ppu_out into res_data; set res_valid=1;
    - pop the FIFO; deassert ap_start; increment issued_cnt;
    - go to RESP.
  - ap_ready is monitored only; advancing is gated solely on ap_done.
- RESP:
  - ap_continue = res_valid & res_ready, combinational, asserted for exactly one cycle.
  - On that cycle, clear res_valid and go to IDLE.
  - The next command can therefore issue two cycles after ap_done at the earliest.
- res_data is stable whenever res_valid=1.
- ap_done pulses seen outside ISSUE are ignored.
- Only one operation is ever outstanding; back-to-back issue without RESP is forbidden.

Optional Feature:
- Macro: PPU_AP_MASTER_TIMEOUT_EN.
- Defined:
  - An 8+ bit watchdog counts cycles in ISSUE.
  - When the count reaches TIMEOUT with no ap_done:
    - drop ap_start; pop the FIFO; set res_data = {1'b1, {WORD-1{1'b0}}} (posit NaR);
    - set res_valid=1; assert sticky output timeout_o; go to RESP;
    - issued_cnt does not increment.
  - timeout_o is cleared only by reset.
- Undefined:
  - No watchdog and no timeout_o port; ISSUE waits indefinitely.

Test Plan:
- Single op: push in1=0x40000000, in2=0x40000000, op=0; model returns ap_done after 3 cycles with ppu_out=0x48000000.
  - Expect ap_start high 3 cycles, res_valid next edge with res_data=0x48000000.
  - With res_ready=1: ap_continue 1 cycle, issued_cnt=1.
- FIFO full: res_ready=0, model never done; push 5 commands with DEPTH=4.
  - Expect cmd_ready=0 after the 4th push accepted (1 issued + 3 queued, or 4 queued before issue).
  - The 5th push stalls until a pop.
- Back-pressure: hold res_ready=0 for 10 cycles after ap_done.
  - Expect res_data stable, ap_continue=0, ap_start=0, no second issue.
  - Then res_ready=1 gives a single ap_continue pulse.
- Stream of 3 ops with ap_done latency 1.
  - Expect results in order, issued_cnt=3, and a 2-cycle minimum gap between ap_start deassert and the next assert.
- Reset mid-ISSUE: assert ap_rst_n=0 while ap_start=1.
  - Next edge: ap_start=0, res_valid=0, cmd_ready=1, busy=0, issued_cnt=0.
- (TIMEOUT_EN, TIMEOUT=8) model never asserts ap_done.
  - After 8 ISSUE cycles: res_data=0x80000000, timeout_o=1, issued_cnt unchanged.

Source files
------------

// File: rtl/ppu_ap_master_if.sv
// rtl/ppu_ap_master_if.sv - command stream, PPU ap handshake and result stream bundle
interface ppu_ap_master_if #(
    parameter int WORD    = 32,
    parameter int OP_SIZE = 3
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [WORD-1:0]    cmd_in1;
    logic [WORD-1:0]    cmd_in2;
    logic [OP_SIZE-1:0] cmd_op;
    logic               ap_start;
    logic               ap_continue;
    logic [WORD-1:0]    ppu_in1;
    logic [WORD-1:0]    ppu_in2;
    logic [OP_SIZE-1:0] ppu_op;
    logic               ap_done;
    logic               ap_ready;
    logic [WORD-1:0]    ppu_out;
    logic               res_valid;
    logic               res_ready;
    logic [WORD-1:0]    res_data;

    modport master (
        input  cmd_valid, cmd_in1, cmd_in2, cmd_op,
        input  ap_done, ap_ready, ppu_out, res_ready,
        output cmd_ready, ap_start, ap_continue, ppu_in1, ppu_in2, ppu_op,
        output res_valid, res_data
    );

    modport slave (
        output cmd_valid, cmd_in1, cmd_in2, cmd_op,
        output ap_done, ap_ready, ppu_out, res_ready,
        input  cmd_ready, ap_start, ap_continue, ppu_in1, ppu_in2, ppu_op,
        input  res_valid, res_data
    );
endinterface

// File: rtl/ppu_ap_master.sv
// rtl/ppu_ap_master.sv - ap_ctrl_hs initiator with command FIFO; PPU_AP_MASTER_TIMEOUT_EN adds an ISSUE watchdog
module ppu_ap_master #(
    parameter int WORD    = 32,
    parameter int OP_SIZE = 3,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    ppu_ap_master_if.master bus,
    output logic        busy,
    output logic [15:0] issued_cnt
`ifdef PPU_AP_MASTER_TIMEOUT_EN
    ,
    output logic        timeout_o
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
        $error("ppu_ap_master: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t state_q, state_d;

    logic [WORD-1:0]    in1_mem [DEPTH];
    logic [WORD-1:0]    in2_mem [DEPTH];
    logic [OP_SIZE-1:0] op_mem  [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               ap_start_q, res_valid_q;
    logic [WORD-1:0]    ppu_in1_q, ppu_in2_q, res_data_q;
    logic [OP_SIZE-1:0] ppu_op_q;
    logic [15:0]        issued_q;

    logic push, pop, do_issue, do_done, do_ack, do_timeout;

`ifdef PPU_AP_MASTER_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [WD_W-1:0] wdog;
    logic            timeout_q;
`endif

    assign bus.cmd_ready   = (count != CNT_W'(DEPTH));
    assign push            = bus.cmd_valid & bus.cmd_ready;
    assign pop             = do_done | do_timeout;
    assign bus.ap_start    = ap_start_q;
    assign bus.ppu_in1     = ppu_in1_q;
    assign bus.ppu_in2     = ppu_in2_q;
    assign bus.ppu_op      = ppu_op_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.ap_continue = do_ack;
    assign busy            = (state_q != IDLE) || (count != '0);
    assign issued_cnt      = issued_q;

    // The current PPU raises ap_ready together with ap_done; progress only ever keys off ap_done.
    assert property (@(posedge ap_clk) disable iff (!ap_rst_n) bus.ap_done |-> bus.ap_ready);

    always_comb begin
        state_d    = state_q;
        do_issue   = 1'b0;
        do_done    = 1'b0;
        do_ack     = 1'b0;
        do_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (count != '0) begin
                    do_issue = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.ap_done) begin
                    do_done = 1'b1;
                    state_d = RESP;
                end
`ifdef PPU_AP_MASTER_TIMEOUT_EN
                else if (wdog == WD_W'(TIMEOUT - 1)) begin
                    do_timeout = 1'b1;
                    state_d    = RESP;
                end
`endif
            end
            RESP: begin
                if (res_valid_q && bus.res_ready) begin
                    do_ack  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO storage carries no reset; occupancy alone defines what is valid.
    always_ff @(posedge ap_clk) begin
        if (push) begin
            in1_mem[wr_ptr] <= bus.cmd_in1;
            in2_mem[wr_ptr] <= bus.cmd_in2;
            op_mem[wr_ptr]  <= bus.cmd_op;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q     <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            ap_start_q  <= 1'b0;
            res_valid_q <= 1'b0;
            ppu_in1_q   <= '0;
            ppu_in2_q   <= '0;
            ppu_op_q    <= '0;
            res_data_q  <= '0;
            issued_q    <= '0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (do_issue) begin
                ppu_in1_q  <= in1_mem[rd_ptr];
                ppu_in2_q  <= in2_mem[rd_ptr];
                ppu_op_q   <= op_mem[rd_ptr];
                ap_start_q <= 1'b1;
            end
            if (do_done) begin
                res_data_q  <= bus.ppu_out;
                res_valid_q <= 1'b1;
                ap_start_q  <= 1'b0;
                issued_q    <= issued_q + 16'd1;
            end
            if (do_timeout) begin
                res_data_q  <= {1'b1, {(WORD-1){1'b0}}};
                res_valid_q <= 1'b1;
                ap_start_q  <= 1'b0;
            end
            if (do_ack) res_valid_q <= 1'b0;
        end
    end

`ifdef PPU_AP_MASTER_TIMEOUT_EN
    assign timeout_o = timeout_q;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            wdog      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (do_issue)              wdog <= '0;
            else if (state_q == ISSUE) wdog <= wdog + WD_W'(1);
            if (do_timeout) timeout_q <= 1'b1;
        end
    end
`endif
endmodule
